cla16_adder: RTL and testbench

- 16-bit two-level carry-lookahead adder with registered outputs.
- Computes s = a + b + ci and produces carry-out plus block-level propagate/generate.
- Intended as the integer add core of the FPU mantissa datapath, next to the CSA tree and shifter.
- The combinational lookahead network feeds one output register stage.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/cla4_group.sv | 42 ++++
 rtl/cla16_adder.sv | 83 ++++++++
 tb/tb_cla16_adder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU mantissa datapath blocks.
// The adder width and lookahead group size are fixed here so every block agrees on them.
package fpu_pkg;

    localparam int ADD_W   = 16;
    localparam int CLA_GRP = 4;
    localparam int NUM_GRP = ADD_W / CLA_GRP;

    // Everything the adder registers on a clock edge, kept together so reset clears it in one step.
    typedef struct packed {
        logic [ADD_W-1:0] s;
        logic             co;
        logic             pg;
        logic             gg;
    } cla_result_t;

    localparam cla_result_t CLA_RESULT_ZERO = '0;

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Internal carries are flat sum-of-products, so no carry ripples between bits.
module cla4_group
    import fpu_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               cin,
    output logic [CLA_GRP-1:0] s,
    output logic               pg,
    output logic               gg
);

    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // pg and gg must not depend on cin; the second-level lookahead relies on that.
    always_comb begin
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    end

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla16_adder.sv
// 16-bit two-level carry-lookahead adder with one output register stage.
// Four cla4_group blocks feed an inline second-level lookahead that supplies their carry-ins.
module cla16_adder
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             ci,
    output logic [ADD_W-1:0] s,
    output logic             co,
    output logic             pg,
    output logic             gg
);

    logic [NUM_GRP-1:0] grp_p;
    logic [NUM_GRP-1:0] grp_g;
    logic [NUM_GRP:0]   grp_c;
    logic [ADD_W-1:0]   sum_next;
    logic               blk_p;
    logic               blk_g;
    cla_result_t        result_next;
    cla_result_t        result_q;

    for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
        cla4_group u_grp (
            .a   (a[k*CLA_GRP +: CLA_GRP]),
            .b   (b[k*CLA_GRP +: CLA_GRP]),
            .cin (grp_c[k]),
            .s   (sum_next[k*CLA_GRP +: CLA_GRP]),
            .pg  (grp_p[k]),
            .gg  (grp_g[k])
        );
    end

    // Group carries c4..c16 come straight from ci and the group P/G terms.
    always_comb begin
        grp_c[0] = ci;
        grp_c[1] = grp_g[0]
                 | (grp_p[0] & ci);
        grp_c[2] = grp_g[1]
                 | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & ci);
        grp_c[3] = grp_g[2]
                 | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & ci);
        grp_c[4] = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & ci);
    end

    assign blk_p = &grp_p;
    assign blk_g = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

    always_comb begin
        result_next    = CLA_RESULT_ZERO;
        result_next.s  = sum_next;
        result_next.co = grp_c[NUM_GRP];
        result_next.pg = blk_p;
        result_next.gg = blk_g;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= CLA_RESULT_ZERO;
        end else begin
            result_q <= result_next;
        end
    end

    assign s  = result_q.s;
    assign co = result_q.co;
    assign pg = result_q.pg;
    assign gg = result_q.gg;

endmodule

// File: tb/tb_cla16_adder.sv
// Self-checking bench for cla16_adder: directed cases, a back-to-back burst and a random stream.
// Expected results are queued when inputs are driven and popped one edge later.
module tb_cla16_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        pg;
        logic        gg;
        logic        ci;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        pg;
    logic        gg;

    exp_t        exp_q[$];
    int          tests_run;
    int          fail_count;

    cla16_adder dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .ci  (ci),
        .s   (s),
        .co  (co),
        .pg  (pg),
        .gg  (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: plain wide arithmetic, no lookahead structure.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mci, input logic mrst);
        exp_t        e;
        logic [16:0] full;
        logic [16:0] no_cin;
        full   = {1'b0, ma} + {1'b0, mb} + {16'd0, mci};
        no_cin = {1'b0, ma} + {1'b0, mb};
        e.ci   = mci;
        if (mrst) begin
            e.s  = 16'h0000;
            e.co = 1'b0;
            e.pg = 1'b0;
            e.gg = 1'b0;
        end else begin
            e.s  = full[15:0];
            e.co = full[16];
            e.pg = ((ma ^ mb) == 16'hFFFF);
            e.gg = no_cin[16];
        end
        return e;
    endfunction

    task automatic checkEq(input string tag, input logic [16:0] obs, input logic [16:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] sb,
                                 input logic sci, input logic srst);
        a   = sa;
        b   = sb;
        ci  = sci;
        rst = srst;
        exp_q.push_back(model(sa, sb, sci, srst));
    endtask

    // Waits for the capturing edge, then compares away from it.
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        tests_run++;
        assert (exp_q.size() > 0) else begin
            fail_count++;
            $error("[TB] FAIL %s_queue: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkEq({tag, "_s"},  {1'b0, s},   {1'b0, e.s});
            checkEq({tag, "_co"}, {16'd0, co}, {16'd0, e.co});
            checkEq({tag, "_pg"}, {16'd0, pg}, {16'd0, e.pg});
            checkEq({tag, "_gg"}, {16'd0, gg}, {16'd0, e.gg});
            checkEq({tag, "_inv"}, {16'd0, co}, {16'd0, gg | (pg & e.ci)});
        end
    endtask

    task automatic step(input logic [15:0] sa, input logic [15:0] sb,
                        input logic sci, input logic srst, input string tag);
        applyStimulus(sa, sb, sci, srst);
        checkOutput(tag);
    endtask

    // Directed literal checks against the hand-derived values.
    task automatic checkLiteral(input string tag, input logic [15:0] es, input logic eco,
                                input logic epg, input logic egg);
        checkEq({tag, "_lit_s"},  {1'b0, s},   {1'b0, es});
        checkEq({tag, "_lit_co"}, {16'd0, co}, {16'd0, eco});
        checkEq({tag, "_lit_pg"}, {16'd0, pg}, {16'd0, epg});
        checkEq({tag, "_lit_gg"}, {16'd0, gg}, {16'd0, egg});
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        rst = 1'b1;
        a   = 16'h0000;
        b   = 16'h0000;
        ci  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(16'h1234, 16'h1111, 1'b1, 1'b1, "reset_hold");
            checkLiteral("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        end

        step(16'h1234, 16'h1111, 1'b1, 1'b0, "reset_release");
        checkLiteral("reset_release", 16'h2346, 1'b0, 1'b0, 1'b0);

        step(16'hAAAA, 16'h5555, 1'b1, 1'b0, "full_chain_ci1");
        checkLiteral("full_chain_ci1", 16'h0000, 1'b1, 1'b1, 1'b0);

        step(16'hAAAA, 16'h5555, 1'b0, 1'b0, "all_prop_ci0");
        checkLiteral("all_prop_ci0", 16'hFFFF, 1'b0, 1'b1, 1'b0);

        step(16'h0610, 16'h02C9, 1'b0, 1'b0, "decimal_add");
        checkLiteral("decimal_add", 16'h08D9, 1'b0, 1'b0, 1'b0);

        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "max_max_ci1");
        checkLiteral("max_max_ci1", 16'hFFFF, 1'b1, 1'b0, 1'b1);

        step(16'hFFFF, 16'h0000, 1'b1, 1'b0, "wrap_to_zero");
        checkLiteral("wrap_to_zero", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Back-to-back burst: a new vector every cycle, each checked exactly one edge later.
        step(16'h0001, 16'h0001, 1'b0, 1'b0, "b2b_0");
        step(16'h00FF, 16'h0001, 1'b0, 1'b0, "b2b_1");
        step(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, "b2b_2");
        step(16'h8000, 16'h8000, 1'b0, 1'b0, "b2b_3");
        step(16'h7FFF, 16'h0000, 1'b1, 1'b0, "b2b_4");
        step(16'h1234, 16'hEDCB, 1'b1, 1'b0, "b2b_5");

        for (int i = 0; i < 10000; i++) begin
            logic r;
            r = (i == 5000) || (i == 5001);
            step(16'($urandom), 16'($urandom), 1'($urandom), r, r ? "rand_rst" : "rand");
        end

        step(16'h4321, 16'h1111, 1'b0, 1'b0, "post_rand");
        checkLiteral("post_rand", 16'h5432, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
